bictr_mod_decode: RTL and testbench

Parametrised up/down counter with arbitrary modulus, selectable wrap or saturate mode, and a registered one-hot decode of the count. It generalises our bidirectional decoded counter: the count range is 0..MODULUS-1 instead of a full power of two, and the block adds synchronous clear, load range checking, and a wrap event pulse. It sits in sequencer and slot-select paths, where the one-hot output drives per-slot enables directly.

---
 rtl/bictr_mod_decode_if.sv | 27 ++
 rtl/bictr_mod_decode.sv | 96 +++++++++
 tb/tb_bictr_mod_decode.sv | 223 ++++++++++++++++++++++
 3 files changed

// File: rtl/bictr_mod_decode_if.sv
// Control/status bundle for the modulus up/down counter with one-hot decode.
// The master side drives the controls; the counter sits on the slave side.
interface bictr_mod_decode_if #(
  parameter int WIDTH   = 4,
  parameter int MODULUS = 12
);
  logic               clr;
  logic               load;
  logic [WIDTH-1:0]   data;
  logic               cen;
  logic               up_dn;
  logic [WIDTH-1:0]   count;
  logic [MODULUS-1:0] count_dec;
  logic               tercnt;
  logic               wrap;
  logic               load_err;

  modport master (
    output clr, load, data, cen, up_dn,
    input  count, count_dec, tercnt, wrap, load_err
  );

  modport slave (
    input  clr, load, data, cen, up_dn,
    output count, count_dec, tercnt, wrap, load_err
  );
endinterface

// File: rtl/bictr_mod_decode.sv
// Up/down counter over 0..MODULUS-1 with wrap or saturate at the ends,
// clamped range-checked load, and a one-hot decode registered alongside the count.
module bictr_mod_decode #(
  parameter int WIDTH    = 4,
  parameter int MODULUS  = 12,
  parameter bit SATURATE = 1'b0
) (
  input logic              clk,
  input logic              reset,
  bictr_mod_decode_if.slave bus
);

  generate
    if (WIDTH < 1 || WIDTH > 16 || MODULUS < 2 || MODULUS > (1 << WIDTH)) begin : g_bad_params
      $error("bictr_mod_decode: illegal WIDTH/MODULUS combination");
    end
  endgenerate

  localparam logic [WIDTH-1:0] MAX_CNT = WIDTH'(MODULUS - 1);

  logic [WIDTH-1:0]   count_q,   next_count;
  logic [MODULUS-1:0] dec_q,     next_dec;
  logic               wrap_q,    next_wrap;
  logic               err_q,     next_err;
  logic               data_ok;

  // A full power-of-two range accepts every load value, so no compare is built.
  generate
    if (MODULUS == (1 << WIDTH)) begin : g_full_range
      assign data_ok = 1'b1;
    end else begin : g_part_range
      assign data_ok = (bus.data < WIDTH'(MODULUS));
    end
  endgenerate

  always_comb begin
    next_count = count_q;
    next_wrap  = 1'b0;
    next_err   = 1'b0;
    if (bus.clr) begin
      next_count = '0;
    end else if (bus.load) begin
      if (data_ok) begin
        next_count = bus.data;
      end else begin
        next_count = MAX_CNT;
        next_err   = 1'b1;
      end
    end else if (bus.cen) begin
      if (bus.up_dn) begin
        if (count_q != MAX_CNT) begin
          next_count = count_q + 1'b1;
        end else if (!SATURATE) begin
          next_count = '0;
          next_wrap  = 1'b1;
        end
      end else begin
        if (count_q != '0) begin
          next_count = count_q - 1'b1;
        end else if (!SATURATE) begin
          next_count = MAX_CNT;
          next_wrap  = 1'b1;
        end
      end
    end
  end

  // Decoding the next value keeps count_dec aligned with count on the same edge.
  always_comb begin
    next_dec = '0;
    for (int i = 0; i < MODULUS; i++) begin
      next_dec[i] = (next_count == WIDTH'(i));
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count_q <= '0;
      dec_q   <= MODULUS'(1);
      wrap_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      count_q <= next_count;
      dec_q   <= next_dec;
      wrap_q  <= next_wrap;
      err_q   <= next_err;
    end
  end

  assign bus.count     = count_q;
  assign bus.count_dec = dec_q;
  assign bus.wrap      = wrap_q;
  assign bus.load_err  = err_q;
  assign bus.tercnt    = bus.up_dn ? (count_q == MAX_CNT) : (count_q == '0);

endmodule

// File: tb/tb_bictr_mod_decode.sv
// Drives a wrapping and a saturating counter with identical stimulus and
// compares both against an arithmetic reference model.
module tb_bictr_mod_decode;

  localparam int WIDTH   = 4;
  localparam int MODULUS = 12;

  logic clk;
  logic reset;

  bictr_mod_decode_if #(.WIDTH(WIDTH), .MODULUS(MODULUS)) bus_w ();
  bictr_mod_decode_if #(.WIDTH(WIDTH), .MODULUS(MODULUS)) bus_s ();

  bictr_mod_decode #(.WIDTH(WIDTH), .MODULUS(MODULUS), .SATURATE(1'b0)) u_wrap (
    .clk   (clk),
    .reset (reset),
    .bus   (bus_w)
  );

  bictr_mod_decode #(.WIDTH(WIDTH), .MODULUS(MODULUS), .SATURATE(1'b1)) u_sat (
    .clk   (clk),
    .reset (reset),
    .bus   (bus_s)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  int m_cnt  [2];
  bit m_wrap [2];
  bit m_err  [2];
  bit cur_up;

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, obs, exp, $time);
  endtask

  task automatic modelReset();
    for (int k = 0; k < 2; k++) begin
      m_cnt[k]  = 0;
      m_wrap[k] = 1'b0;
      m_err[k]  = 1'b0;
    end
  endtask

  // Instance 0 wraps, instance 1 saturates; overflow is found by leaving 0..MODULUS-1.
  task automatic modelStep(input bit c, input bit l, input int d, input bit e, input bit u);
    int nxt;
    for (int k = 0; k < 2; k++) begin
      m_wrap[k] = 1'b0;
      m_err[k]  = 1'b0;
      if (c) begin
        m_cnt[k] = 0;
      end else if (l) begin
        if (d < MODULUS) m_cnt[k] = d;
        else begin
          m_cnt[k] = MODULUS - 1;
          m_err[k] = 1'b1;
        end
      end else if (e) begin
        nxt = u ? m_cnt[k] + 1 : m_cnt[k] - 1;
        if (nxt < 0 || nxt >= MODULUS) begin
          if (k == 0) begin
            m_cnt[k]  = (nxt + MODULUS) % MODULUS;
            m_wrap[k] = 1'b1;
          end
        end else begin
          m_cnt[k] = nxt;
        end
      end
    end
  endtask

  task automatic compareAll();
    int term;
    for (int k = 0; k < 2; k++) begin
      term = cur_up ? int'(m_cnt[k] == MODULUS - 1) : int'(m_cnt[k] == 0);
      if (k == 0) begin
        checkOutput("w.count",    32'(bus_w.count),     32'(m_cnt[0]));
        checkOutput("w.dec",      32'(bus_w.count_dec), 32'(1) << m_cnt[0]);
        checkOutput("w.tercnt",   32'(bus_w.tercnt),    32'(term));
        checkOutput("w.wrap",     32'(bus_w.wrap),      32'(m_wrap[0]));
        checkOutput("w.load_err", 32'(bus_w.load_err),  32'(m_err[0]));
      end else begin
        checkOutput("s.count",    32'(bus_s.count),     32'(m_cnt[1]));
        checkOutput("s.dec",      32'(bus_s.count_dec), 32'(1) << m_cnt[1]);
        checkOutput("s.tercnt",   32'(bus_s.tercnt),    32'(term));
        checkOutput("s.wrap",     32'(bus_s.wrap),      32'(m_wrap[1]));
        checkOutput("s.load_err", 32'(bus_s.load_err),  32'(m_err[1]));
      end
    end
  endtask

  task automatic setInputs(input bit c, input bit l, input int d, input bit e, input bit u);
    bus_w.clr = c;  bus_w.load = l;  bus_w.data = WIDTH'(d);  bus_w.cen = e;  bus_w.up_dn = u;
    bus_s.clr = c;  bus_s.load = l;  bus_s.data = WIDTH'(d);  bus_s.cen = e;  bus_s.up_dn = u;
    cur_up = u;
  endtask

  // One clock with the given controls, then the model steps and both DUTs are checked.
  task automatic applyStimulus(input bit c, input bit l, input int d, input bit e, input bit u);
    setInputs(c, l, d, e, u);
    @(posedge clk);
    modelStep(c, l, d, e, u);
    #1;
    compareAll();
  endtask

  initial begin
    reset = 1'b1;
    setInputs(1'b0, 1'b0, 0, 1'b0, 1'b0);
    modelReset();
    #1;
    checkOutput("rst.count",  32'(bus_w.count),     32'd0);
    checkOutput("rst.dec",    32'(bus_w.count_dec), 32'h001);
    checkOutput("rst.tercnt", 32'(bus_w.tercnt),    32'd1);
    compareAll();
    #2;
    reset = 1'b0;
    setInputs(1'b0, 1'b0, 0, 1'b0, 1'b1);
    #1;
    checkOutput("up.tercnt", 32'(bus_w.tercnt), 32'd0);

    // Up-wrap from 10.
    applyStimulus(1'b0, 1'b1, 10, 1'b0, 1'b1);
    applyStimulus(1'b0, 1'b0, 0, 1'b1, 1'b1);
    checkOutput("upw.c11", 32'(bus_w.count), 32'd11);
    checkOutput("upw.d11", 32'(bus_w.count_dec), 32'h800);
    checkOutput("upw.w11", 32'(bus_w.wrap), 32'd0);
    applyStimulus(1'b0, 1'b0, 0, 1'b1, 1'b1);
    checkOutput("upw.c0", 32'(bus_w.count), 32'd0);
    checkOutput("upw.d0", 32'(bus_w.count_dec), 32'h001);
    checkOutput("upw.w0", 32'(bus_w.wrap), 32'd1);
    applyStimulus(1'b0, 1'b0, 0, 1'b1, 1'b1);
    checkOutput("upw.c1", 32'(bus_w.count), 32'd1);
    checkOutput("upw.d1", 32'(bus_w.count_dec), 32'h002);
    checkOutput("upw.w1", 32'(bus_w.wrap), 32'd0);

    // Down-wrap from 0.
    applyStimulus(1'b1, 1'b0, 0, 1'b0, 1'b0);
    applyStimulus(1'b0, 1'b0, 0, 1'b1, 1'b0);
    checkOutput("dnw.c11", 32'(bus_w.count), 32'd11);
    checkOutput("dnw.w11", 32'(bus_w.wrap), 32'd1);
    applyStimulus(1'b0, 1'b0, 0, 1'b1, 1'b0);
    checkOutput("dnw.c10", 32'(bus_w.count), 32'd10);
    checkOutput("dnw.w10", 32'(bus_w.wrap), 32'd0);

    // Saturation at the top, then stepping back down.
    applyStimulus(1'b0, 1'b1, 11, 1'b0, 1'b1);
    for (int i = 0; i < 4; i++) begin
      applyStimulus(1'b0, 1'b0, 0, 1'b1, 1'b1);
      checkOutput("sat.count",  32'(bus_s.count),  32'd11);
      checkOutput("sat.wrap",   32'(bus_s.wrap),   32'd0);
      checkOutput("sat.tercnt", 32'(bus_s.tercnt), 32'd1);
    end
    applyStimulus(1'b0, 1'b0, 0, 1'b1, 1'b0);
    checkOutput("sat.dn.count",  32'(bus_s.count),  32'd10);
    checkOutput("sat.dn.tercnt", 32'(bus_s.tercnt), 32'd0);

    // Load range checking and priorities.
    applyStimulus(1'b0, 1'b1, 14, 1'b0, 1'b1);
    checkOutput("ld14.count", 32'(bus_w.count),    32'd11);
    checkOutput("ld14.err",   32'(bus_w.load_err), 32'd1);
    applyStimulus(1'b0, 1'b0, 0, 1'b0, 1'b1);
    checkOutput("ld14.err.pulse", 32'(bus_w.load_err), 32'd0);
    applyStimulus(1'b0, 1'b1, 5, 1'b1, 1'b1);
    checkOutput("ld5cen.count", 32'(bus_w.count),    32'd5);
    checkOutput("ld5cen.err",   32'(bus_w.load_err), 32'd0);
    applyStimulus(1'b1, 1'b1, 14, 1'b1, 1'b1);
    checkOutput("clrld.count", 32'(bus_w.count),    32'd0);
    checkOutput("clrld.err",   32'(bus_w.load_err), 32'd0);

    // Asynchronous reset between edges while count is 7.
    applyStimulus(1'b0, 1'b1, 6, 1'b0, 1'b1);
    applyStimulus(1'b0, 1'b0, 0, 1'b1, 1'b1);
    checkOutput("arst.pre", 32'(bus_w.count), 32'd7);
    #3;
    reset = 1'b1;
    #1;
    modelReset();
    checkOutput("arst.count", 32'(bus_w.count),     32'd0);
    checkOutput("arst.dec",   32'(bus_w.count_dec), 32'h001);
    compareAll();
    #2;
    reset = 1'b0;

    // Asynchronous reset clearing a pending load_err and a pending wrap.
    applyStimulus(1'b0, 1'b1, 15, 1'b0, 1'b1);
    #3;
    reset = 1'b1;
    #1;
    modelReset();
    checkOutput("arst.err", 32'(bus_s.load_err), 32'd0);
    compareAll();
    #2;
    reset = 1'b0;
    applyStimulus(1'b0, 1'b0, 0, 1'b1, 1'b0);
    #3;
    reset = 1'b1;
    #1;
    modelReset();
    checkOutput("arst.wrap", 32'(bus_w.wrap), 32'd0);
    compareAll();
    #2;
    reset = 1'b0;

    // Randomized traffic.
    for (int i = 0; i < 400; i++) begin
      applyStimulus($urandom_range(15) == 0, $urandom_range(7) == 0,
                    int'($urandom_range(15)), $urandom_range(3) != 0,
                    1'($urandom_range(1)));
    end

    $display("[TB] %0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
